snd_sched: RTL and testbench
============================

SND_SCHED -- requirements
Module: snd_sched

Interface
REQ-001 SHALL have parameter NSND, 6, number of sound sources.
REQ-002 SHALL have parameter ADDR_W, 20, sound ROM address width.
REQ-003 SHALL have port clk_50  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  in  NSND  per-sound play request pulses, already synchronous to clk_50.
REQ-006 SHALL have port data_ena  in  1  one-cycle sample strobe from codec; consecutive strobes at least 2 cycles apart.
REQ-007 SHALL have port rom_addr  out  ADDR_W  sound ROM read address.
REQ-008 SHALL have port rom_data  in  8  ROM sample, valid 1 cycle after rom_addr changes.
REQ-009 SHALL have port dac_sample  out  16  sample to codec, both channels.
REQ-010 SHALL have port busy  out  1  high in LOAD or PLAY.
REQ-011 SHALL have port cur_snd  out  3  index of sound playing; 7 when none.
REQ-012 SHALL have port done  out  1  one-cycle pulse when a sound completes normally.

Function
REQ-013 SHALL hold pending[NSND]: pending[i] set in any cycle req[i]=1, cleared when sound i is selected; set wins over clear in the same cycle.
REQ-014 SHALL ignore req[i] while sound i is in LOAD or PLAY (no retrigger, pending[i] stays 0).
REQ-015 SHALL select the lowest set index of pending (fixed priority, index 0 highest).
REQ-016 SHALL implement states IDLE, LOAD, PLAY.
REQ-017 IDLE: if pending nonzero -> LOAD next cycle with rom_addr<=start[sel], end_r<=end[sel], cur_snd<=sel, pending[sel]<=0.
REQ-018 LOAD: lasts exactly 1 cycle (ROM latency) -> PLAY; data_ena during LOAD is ignored.
REQ-019 PLAY: on data_ena, dac_sample<={rom_data,8'h00}; if rom_addr==end_r -> IDLE, done=1 next cycle, cur_snd<=7; else rom_addr<=rom_addr+1.
REQ-020 SHALL clear dac_sample to 0 on entering IDLE; dac_sample only changes on data_ena in PLAY or on IDLE entry.
REQ-021 Back-to-back: after completion, a pending sound enters LOAD on the first IDLE cycle (1 idle cycle minimum).
REQ-022 rom_addr SHALL never exceed end_r; equal start and end plays exactly one sample.
REQ-023 Address arithmetic is unsigned ADDR_W bits; table values fit ADDR_W.

Reset
REQ-024 On reset_n=0: state=IDLE, pending=0, rom_addr=0, end_r=0, dac_sample=0, cur_snd=7, busy=0, done=0.
REQ-025 Reset mid-PLAY aborts the sound immediately with no done pulse; requests during reset are lost.

Configuration
REQ-026 With SND_PREEMPT_EN defined: in PLAY, a pending index lower than cur_snd SHALL abort the current sound and go to LOAD next cycle for the new sound; aborted sound is dropped, no done pulse, dac_sample holds its last value.
REQ-027 Without SND_PREEMPT_EN: a playing sound always completes; higher-priority requests wait in pending.

Structure
REQ-028 Package snd_pkg SHALL hold the state enum, sound index constants (0 explosion, 1 ouch, 2 cri, 3 pick_item, 4 tictac, 5 heart_beat), start/end address tables, and CUR_NONE=7.
REQ-029 Sub-module snd_prio_enc (pending vector -> valid + lowest index) SHALL be used.

Verification
REQ-030 req[4] pulse, idle; tictac start 0 end 3846 -> LOAD next cycle, 3847 samples on data_ena, done pulse once, cur_snd 4 then 7.
REQ-031 req[3] and req[0] same cycle -> explosion plays first, then pick_item after 1 idle cycle; two done pulses.
REQ-032 req[4] repeated during tictac playback -> ignored; exactly one playback.
REQ-033 Playing heart_beat, req[0] -> with SND_PREEMPT_EN explosion starts within 2 cycles, no done for heart_beat; without it, explosion starts after heart_beat done.
REQ-034 reset_n low mid-PLAY at rom_addr 100 -> all outputs reset values, no done; req after release plays from start.
REQ-035 ROM model returns rom_data=addr[7:0]; check dac_sample[15:8] sequence matches addresses and dac_sample[7:0]=0.

Source files
------------

// File: rtl/snd_pkg.sv
// Shared types and constants for the sound scheduler: FSM states, sound
// indices and the ROM start/end address table.
package snd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  localparam int TBL_W = 20;

  localparam logic [2:0] SND_EXPLOSION  = 3'd0;
  localparam logic [2:0] SND_OUCH       = 3'd1;
  localparam logic [2:0] SND_CRI        = 3'd2;
  localparam logic [2:0] SND_PICK_ITEM  = 3'd3;
  localparam logic [2:0] SND_TICTAC     = 3'd4;
  localparam logic [2:0] SND_HEART_BEAT = 3'd5;
  localparam logic [2:0] CUR_NONE       = 3'd7;

  // First sample address of each sound in the ROM.
  function automatic logic [TBL_W-1:0] snd_start(input logic [2:0] idx);
    case (idx)
      SND_EXPLOSION:  return 20'd3847;
      SND_OUCH:       return 20'd4047;
      SND_CRI:        return 20'd4147;
      SND_PICK_ITEM:  return 20'd4247;
      SND_TICTAC:     return 20'd0;
      SND_HEART_BEAT: return 20'd4347;
      default:        return '0;
    endcase
  endfunction

  // Last sample address (inclusive) of each sound.
  function automatic logic [TBL_W-1:0] snd_end(input logic [2:0] idx);
    case (idx)
      SND_EXPLOSION:  return 20'd4046;
      SND_OUCH:       return 20'd4146;
      SND_CRI:        return 20'd4246;
      SND_PICK_ITEM:  return 20'd4346;
      SND_TICTAC:     return 20'd3846;
      SND_HEART_BEAT: return 20'd4846;
      default:        return '0;
    endcase
  endfunction

endpackage

// File: rtl/snd_if.sv
// Request, ROM and codec signals of the sound scheduler. master = the
// environment (requesters, ROM, codec); slave = snd_sched.
interface snd_if #(
  parameter int NSND   = 6,
  parameter int ADDR_W = 20
);
  logic [NSND-1:0]   req;
  logic              data_ena;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [15:0]       dac_sample;
  logic              busy;
  logic [2:0]        cur_snd;
  logic              done;

  modport master (
    output req, data_ena, rom_data,
    input  rom_addr, dac_sample, busy, cur_snd, done
  );

  modport slave (
    input  req, data_ena, rom_data,
    output rom_addr, dac_sample, busy, cur_snd, done
  );
endinterface

// File: rtl/snd_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest
// set index (bit 0 wins).
module snd_prio_enc #(
  parameter int N     = 6,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     pend,
  output logic             vld,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    vld = |pend;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i]) idx = IDX_W'(i);
    end
  end
endmodule

// File: rtl/snd_sched.sv
// Sound scheduler: latches play requests, plays the highest-priority sound
// from ROM one sample per codec strobe. Define SND_PREEMPT_EN to let a
// higher-priority request abort the sound currently playing.
module snd_sched
  import snd_pkg::*;
#(
  parameter int NSND   = 6,
  parameter int ADDR_W = 20
) (
  input logic   clk_50,
  input logic   reset_n,
  snd_if.slave  bus
);
  state_t            state;
  logic [NSND-1:0]   pending;
  logic [NSND-1:0]   lock;
  logic [NSND-1:0]   sel_oh;
  logic [ADDR_W-1:0] end_r;
  logic              sel_vld;
  logic [2:0]        sel;
  logic              preempt;
  logic              take;

  snd_prio_enc #(.N(NSND), .IDX_W(3)) u_prio (
    .pend (pending),
    .vld  (sel_vld),
    .idx  (sel)
  );

`ifdef SND_PREEMPT_EN
  assign preempt = (state == S_PLAY) && sel_vld && (sel < bus.cur_snd);
`else
  assign preempt = 1'b0;
`endif

  assign take = ((state == S_IDLE) && sel_vld) || preempt;

  // lock masks retriggers of the sound in LOAD/PLAY; sel_oh clears the pick.
  always_comb begin
    lock   = '0;
    sel_oh = '0;
    if (bus.busy) lock   = NSND'(1) << bus.cur_snd;
    if (take)     sel_oh = NSND'(1) << sel;
  end

  // A new request in the selecting cycle survives the clear.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= (pending & ~sel_oh) | (bus.req & ~lock);
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      bus.rom_addr   <= '0;
      end_r          <= '0;
      bus.dac_sample <= '0;
      bus.cur_snd    <= CUR_NONE;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      // The last sample stays on the DAC for the done cycle, then clears.
      if (state == S_IDLE) bus.dac_sample <= '0;
      if (take) begin
        state        <= S_LOAD;
        bus.rom_addr <= ADDR_W'(snd_start(sel));
        end_r        <= ADDR_W'(snd_end(sel));
        bus.cur_snd  <= sel;
        bus.busy     <= 1'b1;
      end else begin
        case (state)
          S_LOAD: state <= S_PLAY;
          S_PLAY: begin
            if (bus.data_ena) begin
              bus.dac_sample <= {bus.rom_data, 8'h00};
              if (bus.rom_addr == end_r) begin
                state       <= S_IDLE;
                bus.cur_snd <= CUR_NONE;
                bus.busy    <= 1'b0;
                bus.done    <= 1'b1;
              end else begin
                bus.rom_addr <= bus.rom_addr + ADDR_W'(1);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snd_sched.sv
// Randomized directed bench for snd_sched with a behavioural reference
// model of the request/playback rules and a byte-address ROM.
module tb_snd_sched;
  localparam int NSND   = 6;
  localparam int ADDR_W = 20;
`ifdef SND_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic clk_50 = 1'b0;
  logic reset_n;
  always #10 clk_50 = ~clk_50;

  snd_if #(.NSND(NSND), .ADDR_W(ADDR_W)) bus ();

  snd_sched #(.NSND(NSND), .ADDR_W(ADDR_W)) dut (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ROM contents are the low address byte, one cycle of read latency.
  always @(posedge clk_50) bus.rom_data <= bus.rom_addr[7:0];

  int ST[6] = '{3847, 4047, 4147, 4247, 0, 4347};
  int EN[6] = '{4046, 4146, 4246, 4346, 3846, 4846};

  // Reference model: m_snd = sound owning the player (-1 none),
  // m_load = first cycle after selection, in which strobes are dropped.
  int       m_snd, m_addr, m_end, m_dac;
  bit       m_load, m_done;
  bit [5:0] m_pend;

  int       vectors = 0, miscompares = 0;
  int       cyc = 0, dones = 0, t_start = 0, t_req = 0;
  int       started[$];
  bit       last_e, prev_busy;
  int       prev_cur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_snd = -1; m_addr = 0; m_end = 0; m_dac = 0;
    m_load = 0; m_done = 0; m_pend = '0;
  endtask

  task automatic model_begin(input int s);
    m_snd = s; m_load = 1; m_addr = ST[s]; m_end = EN[s]; m_pend[s] = 1'b0;
  endtask

  task automatic model_update(input logic [5:0] r, input bit e);
    int old_snd, sel;
    old_snd = m_snd;
    sel = -1;
    for (int i = 5; i >= 0; i--) if (m_pend[i]) sel = i;
    m_done = 0;
    if (m_snd < 0) begin
      m_dac = 0;
      if (sel >= 0) model_begin(sel);
    end else if (m_load) begin
      m_load = 0;
    end else if (PRE && sel >= 0 && sel < m_snd) begin
      model_begin(sel);
    end else if (e) begin
      m_dac = (m_addr % 256) * 256;
      if (m_addr == m_end) begin
        m_snd = -1; m_done = 1;
      end else begin
        m_addr++;
      end
    end
    for (int i = 0; i < 6; i++)
      if (r[i] && !(old_snd == i)) m_pend[i] = 1'b1;
  endtask

  task automatic check_outputs();
    chk("rom_addr",   32'(bus.rom_addr),   32'(m_addr));
    chk("dac_sample", 32'(bus.dac_sample), 32'(m_dac));
    chk("busy",       32'(bus.busy),       32'(m_snd >= 0));
    chk("cur_snd",    32'(bus.cur_snd),    (m_snd < 0) ? 32'd7 : 32'(m_snd));
    chk("done",       32'(bus.done),       32'(m_done));
  endtask

  task automatic step(input logic [5:0] r);
    bit e;
    e = !last_e && ($urandom_range(0, 1) == 1);
    bus.req = r; bus.data_ena = e; last_e = e;
    @(posedge clk_50);
    model_update(r, e);
    @(negedge clk_50);
    cyc++;
    check_outputs();
    if (bus.done === 1'b1) dones++;
    if (bus.busy === 1'b1 && (!prev_busy || int'(bus.cur_snd) != prev_cur)) begin
      started.push_back(int'(bus.cur_snd));
      t_start = cyc;
    end
    prev_busy = bus.busy;
    prev_cur  = int'(bus.cur_snd);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0; bus.data_ena = 1'b0; last_e = 0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      bus.req = 6'($urandom);
      @(posedge clk_50);
      @(negedge clk_50);
      cyc++;
      check_outputs();
    end
    bus.req = '0; reset_n = 1'b1;
    prev_busy = 0; prev_cur = 7;
  endtask

  // Runs until the player has been idle 3 cycles; optional random requests.
  task automatic wait_quiet(input string tag, input int budget, input logic [5:0] rmask,
                            input bit busy_only);
    int quiet, n;
    logic [5:0] r;
    quiet = 0; n = 0;
    while (n < budget && quiet < 3) begin
      r = '0;
      if (rmask != 0 && $urandom_range(0, 39) == 0 && (!busy_only || bus.busy))
        r = rmask & 6'($urandom);
      step(r);
      n++;
      quiet = bus.busy ? 0 : quiet + 1;
    end
    vectors++;
    assert (quiet >= 3) else begin
      miscompares++;
      $error("FAIL %s_timeout observed=busy expected=idle within %0d cycles", tag, budget);
    end
  endtask

  function automatic int seq_code();
    int c;
    c = 0;
    foreach (started[i]) c = c * 16 + started[i] + 1;
    return c;
  endfunction

  initial begin
    int d0;
    bus.req = '0; bus.data_ena = 1'b0; reset_n = 1'b0;
    do_reset(3);

    // tictac alone: 3847 samples, one done, cur_snd 4 then 7
    started.delete(); dones = 0;
    step(6'b010000);
    step(6'b000000);
    chk("tictac_load_cur", 32'(bus.cur_snd), 32'd4);
    wait_quiet("tictac", 20000, 6'b0, 0);
    chk("tictac_order", seq_code(), 32'h5);
    chk("tictac_dones", dones, 1);
    chk("tictac_cur_none", 32'(bus.cur_snd), 32'd7);

    // explosion and pick_item together: explosion first
    started.delete(); dones = 0;
    step(6'b001001);
    wait_quiet("pair", 5000, 6'b0, 0);
    chk("pair_order", seq_code(), 32'h14);
    chk("pair_dones", dones, 2);

    // tictac retriggered while playing: one playback only
    started.delete(); dones = 0;
    step(6'b010000);
    wait_quiet("retrig", 20000, 6'b010000, 1);
    chk("retrig_order", seq_code(), 32'h5);
    chk("retrig_dones", dones, 1);

    // explosion requested during heart_beat
    started.delete(); dones = 0;
    step(6'b100000);
    for (int i = 0; i < 50; i++) step(6'b0);
    t_req = cyc + 1;
    step(6'b000001);
    wait_quiet("prio", 5000, 6'b0, 0);
    chk("prio_order", seq_code(), 32'h61);
`ifdef SND_PREEMPT_EN
    chk("prio_dones", dones, 1);
    chk("prio_latency_ok", 32'(t_start - t_req <= 2), 32'd1);
`else
    chk("prio_dones", dones, 2);
`endif

    // reset in the middle of tictac at address 100
    started.delete(); dones = 0;
    step(6'b010000);
    for (int n = 0; n < 3000 && bus.rom_addr != 100; n++) step(6'b0);
    chk("abort_addr", 32'(bus.rom_addr), 32'd100);
    d0 = dones;
    do_reset(2);
    chk("abort_no_done", dones, d0);
    chk("abort_cur", 32'(bus.cur_snd), 32'd7);
    started.delete();
    step(6'b010000);
    wait_quiet("restart", 20000, 6'b0, 0);
    chk("restart_order", seq_code(), 32'h5);
    chk("restart_dones", dones, d0 + 1);

    // random short-sound traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 29) == 0) ? (6'b001111 & 6'($urandom)) : 6'b0);
    wait_quiet("random", 10000, 6'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
